// File: rtl/cw_sequencer.sv
// cw_sequencer: microprogram sequencer feeding the datapath one control word per clock.
// It holds a loadable control store and picks the next address from each word's
// sequencing op, branching on the datapath flags.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   load_en/addr/data   control-store write port (rejected while running)
//   start, start_addr   begin execution at start_addr (from idle or halt)
//   stop                abort execution, return to idle
//   V, C, N, Z          flags produced by the word currently issued
//   ControlWord         control word to the datapath (NOP_CW when not running)
//   pc                  address of the word being issued
//   busy, halted        running / halted status
//   load_err            one-cycle pulse after a rejected load
//   issue_count         words issued since the last start, saturating
module cw_sequencer #(
    parameter int unsigned     ADDR_W = 6,
    parameter int unsigned     CW_W   = 55,
    parameter logic [CW_W-1:0] NOP_CW = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic [CW_W+ADDR_W+4:0]   load_data,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic                     stop,
    input  logic                     V,
    input  logic                     C,
    input  logic                     N,
    input  logic                     Z,
    output logic [CW_W-1:0]          ControlWord,
    output logic [ADDR_W-1:0]        pc,
    output logic                     busy,
    output logic                     halted,
    output logic                     load_err,
    output logic [15:0]              issue_count
);

    localparam int unsigned WORD_W = CW_W + ADDR_W + 5;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    localparam logic [2:0] OpJmp  = 3'd1;
    localparam logic [2:0] OpBrt  = 3'd2;
    localparam logic [2:0] OpBrf  = 3'd3;
    localparam logic [2:0] OpHalt = 3'd4;

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

    state_t              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_pc, w_pc_d;
    logic [15:0]         r_count, w_count_d;
    logic                r_load_err;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    logic [WORD_W-1:0]   w_word;
    logic [CW_W-1:0]     w_cw;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [1:0]          w_cond_sel;
    logic [2:0]          w_seq_op;
    logic                w_flag;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [15:0]         w_count_inc;

    // Asynchronous read of the word at pc.
    assign w_word      = r_mem[r_pc];
    assign w_cw        = w_word[CW_W-1:0];
    assign w_next_addr = w_word[CW_W+ADDR_W-1:CW_W];
    assign w_cond_sel  = w_word[CW_W+ADDR_W+1:CW_W+ADDR_W];
    assign w_seq_op    = w_word[CW_W+ADDR_W+4:CW_W+ADDR_W+2];

    // Wraps naturally at the address width.
    assign w_pc_inc    = r_pc + 1'b1;
    assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

    always_comb begin
        w_flag = 1'b0;
        unique case (w_cond_sel)
            2'd0:    w_flag = Z;
            2'd1:    w_flag = N;
            2'd2:    w_flag = C;
            default: w_flag = V;
        endcase
    end

    // Store writes are blocked only while running; a load alongside start still lands.
    always_ff @(posedge clk) begin
        if (load_en && (r_state != StRun)) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_pc       <= '0;
            r_count    <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_count    <= w_count_d;
            r_load_err <= load_en && (r_state == StRun);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_count_d = r_count;
        unique case (r_state)
            StIdle, StHalt: begin
                // stop beats start; a stop from halt just returns to idle.
                if (stop) begin
                    w_state_d = StIdle;
                end else if (start) begin
                    w_state_d = StRun;
                    w_pc_d    = start_addr;
                    w_count_d = '0;
                end
            end
            StRun: begin
                // The word on the bus this cycle counts even if stop aborts now.
                w_count_d = w_count_inc;
                if (stop) begin
                    w_state_d = StIdle;
                end else begin
                    unique case (w_seq_op)
                        OpJmp:   w_pc_d = w_next_addr;
                        OpBrt:   w_pc_d = w_flag ? w_next_addr : w_pc_inc;
                        OpBrf:   w_pc_d = w_flag ? w_pc_inc : w_next_addr;
                        OpHalt:  w_state_d = StHalt;
                        default: w_pc_d = w_pc_inc;
                    endcase
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign ControlWord = (r_state == StRun) ? w_cw : NOP_CW;
    assign pc          = r_pc;
    assign busy        = (r_state == StRun);
    assign halted      = (r_state == StHalt);
    assign load_err    = r_load_err;
    assign issue_count = r_count;

endmodule

// File: tb/tb_cw_sequencer.sv
module tb_cw_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [65:0] load_data = '0;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic        stop = 1'b0;
    logic        V = 1'b0, C = 1'b0, N = 1'b0, Z = 1'b0;
    logic [54:0] ControlWord;
    logic [5:0]  pc;
    logic        busy, halted, load_err;
    logic [15:0] issue_count;

    cw_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .start_addr (start_addr),
        .stop       (stop),
        .V          (V),
        .C          (C),
        .N          (N),
        .Z          (Z),
        .ControlWord(ControlWord),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .load_err   (load_err),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: store contents plus a running/halted view of the sequencer.
    logic [65:0] m_mem [64];
    bit          m_run, m_halt, m_lerr;
    int          m_pc, m_count;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] mk(input int op, input int cond, input int nxt,
                                       input logic [54:0] cw);
        return {3'(op), 2'(cond), 6'(nxt), cw};
    endfunction

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_lerr = 0; m_pc = 0; m_count = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [65:0] w;
        int          op, cond, nxt;
        bit [3:0]    fl;
        bit          taken;
        w    = m_mem[m_pc];
        op   = int'(w[65:63]);
        cond = int'(w[62:61]);
        nxt  = int'(w[60:55]);
        fl   = {V, C, N, Z};
        taken = fl[cond];
        m_lerr = load_en && m_run;
        if (load_en && !m_run) m_mem[load_addr] = load_data;
        if (m_run) begin
            if (m_count < 65535) m_count++;
            if (stop) m_run = 0;
            else if (op == 4) begin m_run = 0; m_halt = 1; end
            else if (op == 1) m_pc = nxt;
            else if (op == 2) m_pc = taken ? nxt : (m_pc + 1) % 64;
            else if (op == 3) m_pc = taken ? (m_pc + 1) % 64 : nxt;
            else m_pc = (m_pc + 1) % 64;
        end else if (stop) begin
            m_halt = 0;
        end else if (start) begin
            m_run = 1; m_halt = 0; m_pc = int'(start_addr); m_count = 0;
        end
    endtask

    // One cycle: compare against the model mid-cycle, step the model, cross the edge.
    task automatic tick();
        logic [54:0] exp_cw;
        @(negedge clk);
        exp_cw = m_run ? m_mem[m_pc][54:0] : 55'h0;
        check_eq("cw", 64'(ControlWord), 64'(exp_cw));
        check_eq("pc", 64'(pc), 64'(m_pc));
        check_eq("busy", 64'(busy), 64'(m_run));
        check_eq("halted", 64'(halted), 64'(m_halt));
        check_eq("load_err", 64'(load_err), 64'(m_lerr));
        check_eq("issue_count", 64'(issue_count), 64'(m_count));
        model_edge();
        @(posedge clk);
        #1;
        load_en = 0; start = 0; stop = 0;
    endtask

    task automatic load(input int addr, input logic [65:0] data);
        load_en = 1; load_addr = 6'(addr); load_data = data;
        tick();
    endtask

    task automatic go(input int addr);
        start = 1; start_addr = 6'(addr);
        tick();
    endtask

    task automatic halt_seq();
        stop = 1;
        tick();
    endtask

    logic [95:0] rnd;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state plus known contents everywhere.
        for (int i = 0; i < 64; i++) load(i, mk(0, 0, 0, 55'(i + 100)));
        check_eq("reset_busy", 64'(busy), 64'(0));

        // Straight-line INC, INC, HALT.
        load(0, mk(0, 0, 0, 55'h1));
        load(1, mk(0, 0, 0, 55'h2));
        load(2, mk(4, 0, 0, 55'h3));
        go(0);
        check_eq("seq_cw1", 64'(ControlWord), 64'h1);
        tick();
        check_eq("seq_cw2", 64'(ControlWord), 64'h2);
        tick();
        check_eq("seq_cw3", 64'(ControlWord), 64'h3);
        tick();
        check_eq("seq_nop", 64'(ControlWord), 64'h0);
        check_eq("seq_halted", 64'(halted), 64'h1);
        check_eq("seq_count", 64'(issue_count), 64'd3);
        check_eq("seq_pc", 64'(pc), 64'd2);
        halt_seq();

        // BRT on Z, then BRF on C.
        load(4, mk(2, 0, 10, 55'h44));
        Z = 1; go(4); tick();
        check_eq("brt_taken_pc", 64'(pc), 64'd10);
        halt_seq();
        Z = 0; go(4); tick();
        check_eq("brt_fall_pc", 64'(pc), 64'd5);
        halt_seq();
        load(4, mk(3, 2, 10, 55'h45));
        C = 1; go(4); tick();
        check_eq("brf_fall_pc", 64'(pc), 64'd5);
        halt_seq();
        C = 0; go(4); tick();
        check_eq("brf_taken_pc", 64'(pc), 64'd10);
        halt_seq();

        // pc wraps from 63 to 0.
        load(63, mk(0, 0, 0, 55'h63));
        load(0, mk(4, 0, 0, 55'h60));
        go(63);
        check_eq("wrap_pc63", 64'(pc), 64'd63);
        tick();
        check_eq("wrap_pc0", 64'(pc), 64'd0);
        tick();
        check_eq("wrap_halted", 64'(halted), 64'h1);
        check_eq("wrap_count", 64'(issue_count), 64'd2);
        halt_seq();

        // Self-loop; rejected load while running; start+stop together.
        load(20, mk(1, 0, 20, 55'h1234));
        go(20); tick();
        load_en = 1; load_addr = 20; load_data = mk(0, 0, 0, 55'h5555);
        tick();
        check_eq("lerr_pulse", 64'(load_err), 64'h1);
        tick();
        check_eq("lerr_clear", 64'(load_err), 64'h0);
        check_eq("lerr_mem_kept", 64'(ControlWord), 64'h1234);
        start = 1; stop = 1; start_addr = 3;
        tick();
        check_eq("startstop_busy", 64'(busy), 64'h0);
        check_eq("startstop_cw", 64'(ControlWord), 64'h0);

        // Issue counter saturation, then restart from zero.
        go(20);
        repeat (70000) tick();
        check_eq("sat_count", 64'(issue_count), 64'hFFFF);
        halt_seq();
        go(20);
        check_eq("restart_count0", 64'(issue_count), 64'd0);
        tick();
        check_eq("restart_count1", 64'(issue_count), 64'd1);

        // Asynchronous reset between edges while running.
        #2 rst = 1;
        #1;
        check_eq("arst_cw", 64'(ControlWord), 64'h0);
        check_eq("arst_busy", 64'(busy), 64'h0);
        check_eq("arst_pc", 64'(pc), 64'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        go(20);
        check_eq("arst_mem_kept", 64'(ControlWord), 64'h1234);
        halt_seq();

        // Randomised programs and control traffic.
        for (int i = 0; i < 64; i++) begin
            rnd = {$urandom, $urandom, $urandom};
            load(i, rnd[65:0]);
        end
        repeat (3000) begin
            rnd = {$urandom, $urandom, $urandom};
            load_en    = ($urandom_range(0, 7) == 0);
            load_addr  = 6'($urandom);
            load_data  = rnd[65:0];
            start      = ($urandom_range(0, 5) == 0);
            start_addr = 6'($urandom);
            stop       = ($urandom_range(0, 9) == 0);
            {V, C, N, Z} = 4'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
